pattern_seq_gen: RTL

- Parametrised successor to the fixed 3-bit up/down bounce counter.
- Generates a programmable numeric sequence between run-time bounds `lo` and `hi`, with a programmable step and four modes: up-wrap, down-wrap, bounce (triangle) and one-shot ramp.
- Values are delivered on a valid/ready stream with an optional cycle count.
- Used as the stimulus/pattern source for display, LED and test-pattern paths.

---
 rtl/pattern_seq_gen.sv | 265 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pattern_seq_gen.sv
// Programmable sequence source: up-wrap, down-wrap, bounce or one-shot ramp between lo and hi.
// Latency: first value is valid one cycle after an accepted start; each transfer advances in one cycle.
// Backpressure: out_data/dir hold while out_valid && !out_ready; stop aborts without a done pulse.
module pattern_seq_gen #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [WIDTH-1:0]  lo,
    input  logic [WIDTH-1:0]  hi,
    input  logic [STEP_W-1:0] step,
    input  logic [CNT_W-1:0]  num_cycles,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    // One extra bit so cur+step and lo+step can never wrap past the bounds.
    localparam int EW = WIDTH + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        M_UP_WRAP   = 2'd0,
        M_DOWN_WRAP = 2'd1,
        M_BOUNCE    = 2'd2,
        M_ONE_SHOT  = 2'd3
    } mode_t;

    state_t              state_q, state_d;
    mode_t               mode_q, mode_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [CNT_W-1:0]    ncyc_q, ncyc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0]    data_q, data_d;
    logic                dir_q, dir_d;
    logic                valid_q, valid_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;

    // Extended-width arithmetic shared by all modes.
    logic [EW-1:0]       cur_e, lo_e, hi_e, step_e;
    logic [EW-1:0]       sum_e, lo_plus_e;
    logic [WIDTH-1:0]    cur_minus, hi_minus;
    logic                sum_above_hi, cur_below, hi_below;

    // Successor of the current value.
    logic [WIDTH-1:0]    nxt_val;
    logic                nxt_dir;
    logic                cyc_done;
    logic                shot_end;
    logic [CNT_W-1:0]    cnt_inc;
    logic                count_end;
    logic                xfer;

    assign xfer = valid_q && out_ready;

    // Bound comparisons in WIDTH+1 bits; the subtractions are only used when they cannot underflow.
    always_comb begin
        cur_e        = {1'b0, data_q};
        lo_e         = {1'b0, lo_q};
        hi_e         = {1'b0, hi_q};
        step_e       = EW'(step_q);
        sum_e        = cur_e + step_e;
        lo_plus_e    = lo_e + step_e;
        cur_minus    = data_q - WIDTH'(step_q);
        hi_minus     = hi_q - WIDTH'(step_q);
        sum_above_hi = sum_e > hi_e;
        cur_below    = cur_e < lo_plus_e;
        hi_below     = hi_e < lo_plus_e;
    end

    // Next value, direction and cycle/end events for a transfer in the current mode.
    always_comb begin
        nxt_val  = data_q;
        nxt_dir  = dir_q;
        cyc_done = 1'b0;
        shot_end = 1'b0;
        case (mode_q)
            M_UP_WRAP: begin
                if (sum_above_hi) begin
                    nxt_val  = lo_q;
                    cyc_done = 1'b1;
                end else begin
                    nxt_val = sum_e[WIDTH-1:0];
                end
            end
            M_DOWN_WRAP: begin
                if (cur_below) begin
                    nxt_val  = hi_q;
                    cyc_done = 1'b1;
                end else begin
                    nxt_val = cur_minus;
                end
            end
            M_BOUNCE: begin
                if (!dir_q) begin
                    if (data_q == hi_q) begin
                        // Turn at the top: hi is emitted once, then head down clamped at lo.
                        nxt_dir = 1'b1;
                        nxt_val = hi_below ? lo_q : hi_minus;
                    end else begin
                        nxt_val = sum_above_hi ? hi_q : sum_e[WIDTH-1:0];
                    end
                end else begin
                    if (data_q == lo_q) begin
                        // Turn at the bottom closes one full triangle.
                        nxt_dir  = 1'b0;
                        nxt_val  = hi_below ? hi_q : lo_plus_e[WIDTH-1:0];
                        cyc_done = 1'b1;
                    end else begin
                        nxt_val = cur_below ? lo_q : cur_minus;
                    end
                end
            end
            default: begin
                if (data_q == hi_q) begin
                    shot_end = 1'b1;
                end else begin
                    nxt_val = sum_above_hi ? hi_q : sum_e[WIDTH-1:0];
                end
            end
        endcase
    end

    // Completed-cycle accounting; num_cycles of zero means run forever.
    always_comb begin
        cnt_inc   = cnt_q + CNT_W'(1);
        count_end = cyc_done && (ncyc_q != '0) && (cnt_inc == ncyc_q);
    end

    // Control FSM next-state: start/config check, advance on transfer, stop and end handling.
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        step_d    = step_q;
        ncyc_d    = ncyc_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        dir_d     = dir_q;
        valid_d   = valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                valid_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    if ((lo <= hi) && (step != '0)) begin
                        state_d = S_RUN;
                        mode_d  = mode_t'(mode);
                        lo_d    = lo;
                        hi_d    = hi;
                        step_d  = step;
                        ncyc_d  = num_cycles;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        if (mode_t'(mode) == M_DOWN_WRAP) begin
                            data_d = hi;
                            dir_d  = 1'b1;
                        end else begin
                            data_d = lo;
                            dir_d  = 1'b0;
                        end
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (stop) begin
                    // Abort wins over a count end; a beat taken this cycle still counts as delivered.
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (xfer) begin
                    data_d = nxt_val;
                    dir_d  = nxt_dir;
                    if (cyc_done) begin
                        cnt_d = cnt_inc;
                    end
                    if (count_end || shot_end) begin
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // All state and registered outputs; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            mode_q    <= M_UP_WRAP;
            lo_q      <= '0;
            hi_q      <= '0;
            step_q    <= '0;
            ncyc_q    <= '0;
            cnt_q     <= '0;
            data_q    <= '0;
            dir_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            step_q    <= step_d;
            ncyc_q    <= ncyc_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            dir_q     <= dir_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cfg_err   = cfg_err_q;

endmodule
